// File: rtl/ask_demod.sv
// ASK demodulator: it turns ADC samples into a windowed envelope, slices the
// envelope with hysteresis, and recovers bits from level edges.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   adc_data, adc_valid  offset-binary sample stream
//   thr_hi, thr_lo       slicer thresholds
//   env, env_valid       window mean magnitude and its update pulse
//   bit_out, bit_valid   recovered bit and its update pulse
//   lock                 high while bit timing is tracking
`timescale 1ns/1ps
module ask_demod #(
  parameter int WIN_LOG2 = 4,
  parameter int SYM_WIN  = 15625,
  parameter int MAX_RUN  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] adc_data,
  input  logic        adc_valid,
  input  logic [13:0] thr_hi,
  input  logic [13:0] thr_lo,
  output logic [13:0] env,
  output logic        env_valid,
  output logic        bit_out,
  output logic        bit_valid,
  output logic        lock
);
  localparam int AW = 14 + WIN_LOG2;
  localparam int WW = $clog2(SYM_WIN + 1);
  localparam int RW = $clog2(MAX_RUN + 1);
  localparam logic [WW-1:0] HALF  = WW'(SYM_WIN / 2);
  localparam logic [WW-1:0] WLAST = WW'(SYM_WIN - 1);
  localparam logic [RW-1:0] RLAST = RW'(MAX_RUN);

  typedef enum logic {HUNT, TRACK} state_t;

  logic [13:0]         s;
  logic [13:0]         mag_c;
  logic [13:0]         mag;
  logic                mag_v;
  logic [WIN_LOG2-1:0] scnt;
  logic [AW-1:0]       acc;
  logic [AW-1:0]       sum;
  logic                level;
  logic                prev_lvl;
  logic                lvl_v;
  logic                lvl_edge;
  state_t              state_q;
  state_t              state_n;
  logic [WW-1:0]       wcnt;
  logic [WW-1:0]       wcnt_n;
  logic [WW-1:0]       wcnt_inc;
  logic [RW-1:0]       run;
  logic [RW-1:0]       run_n;
  logic [RW-1:0]       run_inc;
  logic                fresh;
  logic                fresh_n;
  logic                emit;

  // Flipping the MSB turns offset binary into two's complement.
  assign s = {~adc_data[13], adc_data[12:0]};

  // -8192 has no positive twin in 14 bits, so it clips to 8191.
  always_comb begin
    mag_c = s;
    if (s[13]) begin
      mag_c = (s == 14'h2000) ? 14'h1FFF : (~s + 14'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mag   <= '0;
      mag_v <= 1'b0;
    end else begin
      mag_v <= adc_valid;
      if (adc_valid) mag <= mag_c;
    end
  end

  assign sum = acc + AW'(mag);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      scnt      <= '0;
      env       <= '0;
      env_valid <= 1'b0;
    end else begin
      env_valid <= 1'b0;
      if (mag_v) begin
        scnt <= scnt + 1'b1;
        if (scnt == '1) begin
          env       <= sum[AW-1:WIN_LOG2];
          acc       <= '0;
          env_valid <= 1'b1;
        end else begin
          acc <= sum;
        end
      end
    end
  end

  // The high threshold wins, so thr_lo > thr_hi acts as a single threshold.
  always_ff @(posedge clk) begin
    if (rst) begin
      level    <= 1'b0;
      prev_lvl <= 1'b0;
      lvl_v    <= 1'b0;
    end else begin
      lvl_v <= env_valid;
      if (env_valid) begin
        if (env >= thr_hi) level <= 1'b1;
        else if (env < thr_lo) level <= 1'b0;
      end
      if (lvl_v) prev_lvl <= level;
    end
  end

  assign lvl_edge = lvl_v && (level != prev_lvl);
  assign wcnt_inc = (wcnt == WLAST) ? '0 : wcnt + 1'b1;
  assign run_inc  = run + 1'b1;

  // fresh marks that an edge happened since the last emitted bit.
  always_comb begin
    state_n = state_q;
    wcnt_n  = wcnt;
    run_n   = run;
    fresh_n = fresh;
    emit    = 1'b0;
    if (lvl_v) begin
      if (lvl_edge) begin
        state_n = TRACK;
        wcnt_n  = '0;
        run_n   = '0;
        fresh_n = 1'b1;
      end else begin
        wcnt_n = wcnt_inc;
        if (state_q == TRACK && wcnt_inc == HALF) begin
          emit    = 1'b1;
          fresh_n = 1'b0;
          if (!fresh) begin
            run_n = run_inc;
            if (run_inc == RLAST) state_n = HUNT;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= HUNT;
      wcnt      <= '0;
      run       <= '0;
      fresh     <= 1'b0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
    end else begin
      state_q   <= state_n;
      wcnt      <= wcnt_n;
      run       <= run_n;
      fresh     <= fresh_n;
      bit_valid <= emit;
      if (emit) bit_out <= level;
    end
  end

  assign lock = (state_q == TRACK);

endmodule

// File: doc/ask_demod.md
ASK_DEMOD -- requirements
Module: ask_demod

Interface
REQ-001 Parameter WIN_LOG2, default 4, log2 of the samples per envelope window.
REQ-002 Parameter SYM_WIN, default 15625, envelope windows per symbol (250000 clk at 16 samples/window).
REQ-003 Parameter MAX_RUN, default 8, symbols without a level edge before lock is dropped.
REQ-004 clk  in  1  single system clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 adc_data  in  14  ADC sample, offset binary (0x2000 = zero).
REQ-007 adc_valid  in  1  sample strobe; adc_data is accepted only when high.
REQ-008 thr_hi  in  14  envelope threshold for level=1.
REQ-009 thr_lo  in  14  envelope threshold for level=0.
REQ-010 env  out  14  last window mean magnitude, unsigned.
REQ-011 env_valid  out  1  one-cycle pulse when env updates.
REQ-012 bit_out  out  1  recovered data bit.
REQ-013 bit_valid  out  1  one-cycle pulse when bit_out updates.
REQ-014 lock  out  1  high while bit timing is tracking.

Function
REQ-015 Stage 1, registered, on adc_valid: s = adc_data with MSB inverted (two's complement); mag = |s|; s = -8192 saturates to 8191; mag_v = adc_valid delayed 1 cycle.
REQ-016 Stage 2, on mag_v: acc (14+WIN_LOG2 bits, no overflow possible) += mag; sample counter wraps at 2^WIN_LOG2-1.
REQ-017 On the last sample of a window: env <= (acc+mag)>>WIN_LOG2, acc <= 0, env_valid = 1 the same cycle env updates; latency from last accepted adc_valid to env_valid = 2 cycles.
REQ-018 Gaps in adc_valid stall the pipeline without losing samples; windows always contain exactly 2^WIN_LOG2 accepted samples.
REQ-019 Slicer, cycle after env_valid: level <= 1 if env >= thr_hi; else level <= 0 if env < thr_lo; else level holds (hysteresis); thr_hi check has priority.
REQ-020 Edge = level differs from its value at the previous window; evaluated once per window.
REQ-021 Window counter wcnt (0..SYM_WIN-1) advances once per window, wraps SYM_WIN-1 -> 0.
REQ-022 FSM state HUNT (reset): lock=0, no bit_valid; on edge -> TRACK, wcnt <= 0, run <= 0.
REQ-023 State TRACK: lock=1; on edge wcnt <= 0 and run <= 0 (resync); when wcnt reaches SYM_WIN/2 (integer divide), bit_out <= level and bit_valid pulses 1 cycle after the level update for that window.
REQ-024 In TRACK, each emitted bit with no edge since the previous bit increments run; when run reaches MAX_RUN -> HUNT, lock <= 0 the next cycle, no further bit_valid.
REQ-025 Edge and mid-symbol sample coinciding in one window: resync takes priority, no bit emitted that window.
REQ-026 thr_lo > thr_hi is legal: behaves as a single threshold at thr_hi.

Reset
REQ-027 While rst is high: env=0, env_valid=0, bit_out=0, bit_valid=0, lock=0, level=0, acc=0, counters=0, FSM=HUNT, pipeline valids cleared.
REQ-028 rst mid-window discards the partial window; the first window after reset starts at the next accepted sample.
REQ-029 rst held 1 cycle fully resets; outputs are at reset values on the first cycle after rst deasserts.

Verification (WIN_LOG2=2, SYM_WIN=8, MAX_RUN=3 unless noted)
REQ-030 rst pulse mid-operation -> all outputs 0 next cycle, lock=0, first env_valid after exactly 4 new accepted samples.
REQ-031 adc_data=0x0000 and 0x3FFF continuous, adc_valid=1 -> env=8191 (saturated / max), env_valid every 4 cycles, 2-cycle latency.
REQ-032 adc_valid toggled every other cycle, adc_data=0x2000+1000 -> env=1000, env_valid every 8 cycles.
REQ-033 thr_hi=2000, thr_lo=1000, amplitude alternating 4000 / 0 every 32 samples -> lock=1 after first edge, bit_out alternates 1,0,1,... one bit_valid per 32 samples, sampled 4 windows after each edge.
REQ-034 env held at 1500 between thresholds after level=1 -> level stays 1; then env=500 -> level 0.
REQ-035 Modulation stops (constant amplitude 4000) while locked -> exactly 3 more bit_valid pulses of value 1, then lock=0, FSM=HUNT.
